regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the single write port of `Vr_register_file`. It accepts write requests from two producers, the ALU (port A) and the load unit (port B). Each producer feeds its own small FIFO, and the arbiter drains the two FIFOs round-robin, one write per cycle, onto the register file's WE/WR/WD. It also reports read-after-write hazards for the two read addresses, so decode can stall while a write to that register is still in flight.

## Interface
- DEPTH, 2: entries per requester FIFO; power of two, ≥2.
- AW, 5: register address width.
- DW, 32: write data width.

- CLK  in  1  single clock, all state on rising edge.
- RST_N  in  1  reset, synchronous and active-low.
- A_VALID  in  1  requester A (ALU) has a write.
- A_READY  out  1  A FIFO can accept; transfer when A_VALID && A_READY at edge.
- A_WR  in  AW  A destination register.
- A_WD  in  DW  A write data.
- B_VALID, B_READY, B_WR, B_WD: same as A, for requester B (load unit).
- WE  out  1  write enable to register file.
- WR  out  AW  write register to register file.
- WD  out  DW  write data to register file.
- RR1  in  AW  read address 1 (same value presented to register file).
- RR2  in  AW  read address 2.
- HAZ1  out  1  a pending write targets RR1.
- HAZ2  out  1  a pending write targets RR2.
- IDLE  out  1  both FIFOs empty and WE=0.

## Operation
- Each requester has a DEPTH-entry FIFO holding {WR, WD}. READY = !full && RST_N.
  - No push is accepted while full, even if a pop happens in the same cycle.
- Per cycle, the arbiter examines the two FIFO heads:
  - Only one non-empty: grant it.
  - Both non-empty: grant the side selected by priority pointer PRI.
  - After any grant, PRI points to the other requester.
- On grant, the head is popped and the output register loads WE=1, WR=head.WR, WD=head.WD.
- With no grant, the output register loads WE=0; WR/WD hold their previous values.
- Entries from one requester are written in acceptance order. Across requesters, order follows arbitration only.
- The same register queued by both sides is not merged; both writes occur, in grant order.
- HAZ1 is combinational and asserts when RR1 equals WR of any valid entry in either FIFO, or equals the output WR while WE=1. HAZ2 is the same for RR2.
- Register 0 is not special; writes to it are performed and hazard-checked like any other register.
- Push and pop on the same FIFO in one cycle (not full): count is unchanged, and head and tail pointers both advance and wrap modulo DEPTH.

## Timing
- Reset: when RST_N=0 at an edge:
  - FIFOs are emptied and pointers cleared.
  - PRI=A; WE=0, WR=0, WD=0.
  - A_READY=B_READY=0 while RST_N is low.
  - HAZ1=HAZ2=0 and IDLE=1 after the edge.
- Reset mid-operation discards all queued entries. No WE pulse occurs on the cycle following the reset edge.
- Latency: an entry accepted at edge k, into an empty FIFO with no contention, is granted and appears on WE/WR/WD after edge k+1. The register file writes it at edge k+2.
- Under continuous contention, each requester gets one write every 2 cycles. Total throughput is 1 write/cycle.
- WE is high for exactly one cycle per granted entry; there are no bubbles while any FIFO is non-empty.
- HAZ covers an entry from the cycle after it is accepted through the cycle in which it is on WR with WE=1. It deasserts after the register file's write edge, at which point the register file read returns the new value.

## Structure
- Package `regfile_wb_pkg`:
  - constants for default AW, DW, DEPTH;
  - enum `req_e` {REQ_A, REQ_B} for PRI and grant;
  - packed struct `wb_entry_t` {WR, WD}.
- Sub-module `wb_fifo`: parameterised DEPTH, instantiated twice. It exposes full, empty, head, push, pop, and a per-entry valid/WR vector for hazard compare.
- The top holds the arbiter, PRI, the output register, the hazard compare and IDLE.

## Test plan
- Reset: hold RST_N=0 for 2 cycles with A_VALID=1 -> READY=0, WE=0, IDLE=1, no write occurs. Release -> A_READY=1.
- Single write: A pushes WR=5, WD=0xDEADBEEF at edge k -> WE=1, WR=5, WD=0xDEADBEEF after edge k+1, for one cycle only. HAZ1=1 with RR1=5 from after edge k until after edge k+2.
- Contention: A and B each push 3 entries back-to-back -> WE sequence A0,B0,A1,B1,A2,B2 with no idle cycles; PRI alternates.
- Full/backpressure: B_VALID held high while WE drain is blocked by A contention, DEPTH=2 -> B_READY drops after 2 unpopped pushes. No entry is lost or duplicated, and all B entries are written in order.
- Same-register race: A writes r7=1, B writes r7=2 in the same cycle, PRI=A -> r7=1 then r7=2; final register file value is 2. HAZ1 (RR1=7) stays high until the second write completes.
- Reset mid-operation: 3 entries queued, then RST_N=0 for one edge -> FIFOs empty, WE=0 next cycle, IDLE=1, none of the queued writes reach the register file.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared types and default sizes for the register-file write-back arbiter.
package regfile_wb_pkg;

  localparam int DEF_AW    = 5;
  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 2;

  // Requester identity, used for the round-robin pointer and the grant.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  // One queued write at the default widths.
  typedef struct packed {
    logic [DEF_AW-1:0] wr;
    logic [DEF_DW-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small per-requester write FIFO. Besides the usual head/full/empty it exposes
// every slot's valid bit and destination register so the owner can do a
// parallel read-after-write hazard compare across all queued writes.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic [AW-1:0]             push_wr_i,
  input  logic [DW-1:0]             push_wd_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [AW-1:0]             head_wr_o,
  output logic [DW-1:0]             head_wd_o,
  output logic [DEPTH-1:0]          ent_valid_o,
  output logic [DEPTH-1:0][AW-1:0]  ent_wr_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    wr_mem_q [DEPTH];
  logic [DW-1:0]    wd_mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full FIFO refuses a push even when it is popped in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign head_wr_o   = wr_mem_q[head_q];
  assign head_wd_o   = wd_mem_q[head_q];
  assign ent_valid_o = valid_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign ent_wr_o[gi] = wr_mem_q[gi];
    end
  endgenerate

  // Next-state for pointers, occupancy and per-slot valid bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    if (pop_ok) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push_ok) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage; contents are meaningless unless the slot's valid bit is set.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      wr_mem_q[tail_q] <= push_wr_i;
      wd_mem_q[tail_q] <= push_wd_i;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: drains the ALU (A) and load-unit (B) FIFOs round-robin
// onto the register file's single write port and flags read-after-write
// hazards for the two read addresses.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          A_VALID,
  output logic          A_READY,
  input  logic [AW-1:0] A_WR,
  input  logic [DW-1:0] A_WD,
  input  logic          B_VALID,
  output logic          B_READY,
  input  logic [AW-1:0] B_WR,
  input  logic [DW-1:0] B_WD,
  output logic          WE,
  output logic [AW-1:0] WR,
  output logic [DW-1:0] WD,
  input  logic [AW-1:0] RR1,
  input  logic [AW-1:0] RR2,
  output logic          HAZ1,
  output logic          HAZ2,
  output logic          IDLE
);

  logic                     full_a, empty_a, full_b, empty_b;
  logic [AW-1:0]            head_wr_a, head_wr_b;
  logic [DW-1:0]            head_wd_a, head_wd_b;
  logic [DEPTH-1:0]         valid_a, valid_b;
  logic [DEPTH-1:0][AW-1:0] ent_wr_a, ent_wr_b;
  logic                     push_a, push_b;
  logic                     grant_a, grant_b;

  req_e          pri_q, pri_d;
  logic          we_q, we_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [DW-1:0] wd_q, wd_d;

  // READY is forced low while reset is held so nothing is accepted then.
  assign A_READY = !full_a && RST_N;
  assign B_READY = !full_b && RST_N;
  assign push_a  = A_VALID && A_READY;
  assign push_b  = B_VALID && B_READY;

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_a (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .push_i      (push_a),
    .push_wr_i   (A_WR),
    .push_wd_i   (A_WD),
    .pop_i       (grant_a),
    .full_o      (full_a),
    .empty_o     (empty_a),
    .head_wr_o   (head_wr_a),
    .head_wd_o   (head_wd_a),
    .ent_valid_o (valid_a),
    .ent_wr_o    (ent_wr_a)
  );

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_b (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .push_i      (push_b),
    .push_wr_i   (B_WR),
    .push_wd_i   (B_WD),
    .pop_i       (grant_b),
    .full_o      (full_b),
    .empty_o     (empty_b),
    .head_wr_o   (head_wr_b),
    .head_wd_o   (head_wd_b),
    .ent_valid_o (valid_b),
    .ent_wr_o    (ent_wr_b)
  );

  // Grant a lone non-empty side, otherwise follow the priority pointer.
  always_comb begin
    grant_a = !empty_a && (empty_b || (pri_q == REQ_A));
    grant_b = !empty_b && (empty_a || (pri_q == REQ_B));
  end

  // Priority flips to the other requester after every grant; output register
  // loads the granted head, or drops WE and holds WR/WD when idle.
  always_comb begin
    pri_d = pri_q;
    we_d  = grant_a || grant_b;
    wr_d  = wr_q;
    wd_d  = wd_q;
    if (grant_a) begin
      pri_d = REQ_B;
      wr_d  = head_wr_a;
      wd_d  = head_wd_a;
    end else if (grant_b) begin
      pri_d = REQ_A;
      wr_d  = head_wr_b;
      wd_d  = head_wd_b;
    end
  end

  // Arbiter and output-register state with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pri_q <= REQ_A;
      we_q  <= 1'b0;
      wr_q  <= '0;
      wd_q  <= '0;
    end else begin
      pri_q <= pri_d;
      we_q  <= we_d;
      wr_q  <= wr_d;
      wd_q  <= wd_d;
    end
  end

  assign WE = we_q;
  assign WR = wr_q;
  assign WD = wd_q;

  // Hazard: any queued entry or the in-flight output write targets the read
  // address. Register 0 is compared like every other register.
  logic [DEPTH-1:0] hit1_a, hit1_b, hit2_a, hit2_b;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_haz
      assign hit1_a[gi] = valid_a[gi] && (ent_wr_a[gi] == RR1);
      assign hit1_b[gi] = valid_b[gi] && (ent_wr_b[gi] == RR1);
      assign hit2_a[gi] = valid_a[gi] && (ent_wr_a[gi] == RR2);
      assign hit2_b[gi] = valid_b[gi] && (ent_wr_b[gi] == RR2);
    end
  endgenerate

  assign HAZ1 = (|hit1_a) || (|hit1_b) || (we_q && (wr_q == RR1));
  assign HAZ2 = (|hit2_a) || (|hit2_b) || (we_q && (wr_q == RR2));
  assign IDLE = empty_a && empty_b && !we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with a behavioural
// register file that commits WD to WR on every edge where WE is high.
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          A_VALID, B_VALID;
  logic          A_READY, B_READY;
  logic [AW-1:0] A_WR, B_WR;
  logic [DW-1:0] A_WD, B_WD;
  logic          WE;
  logic [AW-1:0] WR;
  logic [DW-1:0] WD;
  logic [AW-1:0] RR1, RR2;
  logic          HAZ1, HAZ2, IDLE;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
    int            c;
  } log_t;

  log_t          wlog[$];
  logic [DW-1:0] rf [32];

  wb_entry_t a_tab [8];
  wb_entry_t b_tab [8];
  int        b_stall;
  int        run_budget;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .A_VALID (A_VALID),
    .A_READY (A_READY),
    .A_WR    (A_WR),
    .A_WD    (A_WD),
    .B_VALID (B_VALID),
    .B_READY (B_READY),
    .B_WR    (B_WR),
    .B_WD    (B_WD),
    .WE      (WE),
    .WR      (WR),
    .WD      (WD),
    .RR1     (RR1),
    .RR2     (RR2),
    .HAZ1    (HAZ1),
    .HAZ2    (HAZ2),
    .IDLE    (IDLE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Register-file model and write log.
  always @(posedge CLK) begin
    if (WE === 1'b1) begin
      rf[WR] <= WD;
      wlog.push_back('{wr: WR, wd: WD, c: cyc});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    RST_N   = 1'b0;
    tick();
    RST_N   = 1'b1;
  endtask

  // Drives na entries from a_tab and nb from b_tab with valid/ready handshakes,
  // then waits for the arbiter to drain.
  task automatic run_streams(input int na, input int nb);
    int  ia = 0;
    int  ib = 0;
    bit  fa, fb;
    b_stall    = 0;
    run_budget = 0;
    while ((ia < na || ib < nb) && run_budget < 60) begin
      A_VALID = (ia < na);
      B_VALID = (ib < nb);
      if (ia < na) begin A_WR = a_tab[ia].wr; A_WD = a_tab[ia].wd; end
      if (ib < nb) begin B_WR = b_tab[ib].wr; B_WD = b_tab[ib].wd; end
      #1;
      fa = A_VALID && A_READY;
      fb = B_VALID && B_READY;
      if (B_VALID && !B_READY) b_stall++;
      tick();
      if (fa) ia++;
      if (fb) ib++;
      run_budget++;
    end
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    for (int k = 0; k < 20 && IDLE !== 1'b1; k++) begin
      tick();
      run_budget++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; A_VALID = 1'b1; B_VALID = 1'b0;
    A_WR = 5'd3; A_WD = 32'h1111_1111; B_WR = '0; B_WD = '0;
    RR1 = 5'd3; RR2 = 5'd4;
    tick();
    tick();
    total_cnt++; if (A_READY !== 1'b0) $display("FAIL reset_a_ready: got %b want 0", A_READY); else pass_cnt++;
    total_cnt++; if (B_READY !== 1'b0) $display("FAIL reset_b_ready: got %b want 0", B_READY); else pass_cnt++;
    total_cnt++; if (WE !== 1'b0) $display("FAIL reset_we: got %b want 0", WE); else pass_cnt++;
    total_cnt++; if (IDLE !== 1'b1) $display("FAIL reset_idle: got %b want 1", IDLE); else pass_cnt++;
    total_cnt++; if (HAZ1 !== 1'b0 || HAZ2 !== 1'b0) $display("FAIL reset_haz: got %b%b want 00", HAZ1, HAZ2); else pass_cnt++;
    total_cnt++; if (WR !== '0 || WD !== '0) $display("FAIL reset_wr_wd: got %h/%h want 0/0", WR, WD); else pass_cnt++;
    A_VALID = 1'b0;
    RST_N   = 1'b1;
    #1;
    total_cnt++; if (A_READY !== 1'b1) $display("FAIL release_a_ready: got %b want 1", A_READY); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (wlog.size() != 0) $display("FAIL reset_no_write: got %0d writes want 0", wlog.size()); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    int n0;
    do_reset();
    n0 = wlog.size();
    A_VALID = 1'b1; A_WR = 5'd5; A_WD = 32'hDEAD_BEEF; RR1 = 5'd5; RR2 = 5'd6;
    #1;
    total_cnt++; if (HAZ1 !== 1'b0) $display("FAIL single_haz_before: got %b want 0", HAZ1); else pass_cnt++;
    tick();
    A_VALID = 1'b0;
    total_cnt++; if (HAZ1 !== 1'b1) $display("FAIL single_haz_queued: got %b want 1", HAZ1); else pass_cnt++;
    total_cnt++; if (WE !== 1'b0) $display("FAIL single_we_k: got %b want 0", WE); else pass_cnt++;
    tick();
    total_cnt++; if (WE !== 1'b1 || WR !== 5'd5 || WD !== 32'hDEAD_BEEF)
      $display("FAIL single_out: got we=%b wr=%0d wd=%h want we=1 wr=5 wd=deadbeef", WE, WR, WD); else pass_cnt++;
    total_cnt++; if (HAZ1 !== 1'b1 || HAZ2 !== 1'b0) $display("FAIL single_haz_out: got %b%b want 10", HAZ1, HAZ2); else pass_cnt++;
    tick();
    total_cnt++; if (WE !== 1'b0) $display("FAIL single_we_once: got %b want 0", WE); else pass_cnt++;
    total_cnt++; if (HAZ1 !== 1'b0) $display("FAIL single_haz_after: got %b want 0", HAZ1); else pass_cnt++;
    total_cnt++; if (rf[5] !== 32'hDEAD_BEEF) $display("FAIL single_rf: got %h want deadbeef", rf[5]); else pass_cnt++;
    total_cnt++; if (IDLE !== 1'b1 || wlog.size() != n0 + 1)
      $display("FAIL single_idle_count: got idle=%b writes=%0d want idle=1 writes=1", IDLE, wlog.size() - n0); else pass_cnt++;
    $display("test_single done");
  endtask

  task automatic test_reg0();
    do_reset();
    B_VALID = 1'b1; B_WR = 5'd0; B_WD = 32'hCAFE_0000; RR1 = 5'd1; RR2 = 5'd0;
    tick();
    B_VALID = 1'b0;
    total_cnt++; if (HAZ2 !== 1'b1 || HAZ1 !== 1'b0) $display("FAIL reg0_haz_queued: got %b%b want 01", HAZ1, HAZ2); else pass_cnt++;
    tick();
    total_cnt++; if (WE !== 1'b1 || WR !== 5'd0 || WD !== 32'hCAFE_0000)
      $display("FAIL reg0_out: got we=%b wr=%0d wd=%h want we=1 wr=0 wd=cafe0000", WE, WR, WD); else pass_cnt++;
    tick();
    total_cnt++; if (HAZ2 !== 1'b0) $display("FAIL reg0_haz_after: got %b want 0", HAZ2); else pass_cnt++;
    total_cnt++; if (rf[0] !== 32'hCAFE_0000) $display("FAIL reg0_rf: got %h want cafe0000", rf[0]); else pass_cnt++;
    $display("test_reg0 done");
  endtask

  task automatic test_contention();
    int        n0;
    wb_entry_t exp_e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_tab[i].wr = AW'(1 + i);  a_tab[i].wd = 32'hA000_0000 + i;
      b_tab[i].wr = AW'(11 + i); b_tab[i].wd = 32'hB000_0000 + i;
    end
    RR1 = 5'd31; RR2 = 5'd30;
    n0 = wlog.size();
    run_streams(3, 3);
    total_cnt++; if (IDLE !== 1'b1) $display("FAIL cont_timeout: idle=%b after %0d cycles want 1", IDLE, run_budget); else pass_cnt++;
    total_cnt++; if (wlog.size() - n0 != 6) $display("FAIL cont_count: got %0d writes want 6", wlog.size() - n0); else pass_cnt++;
    for (int k = 0; k < 6 && n0 + k < wlog.size(); k++) begin
      exp_e = (k % 2 == 0) ? a_tab[k/2] : b_tab[k/2];
      total_cnt++;
      if (wlog[n0+k].wr !== exp_e.wr || wlog[n0+k].wd !== exp_e.wd)
        $display("FAIL cont_order[%0d]: got r%0d=%h want r%0d=%h", k, wlog[n0+k].wr, wlog[n0+k].wd, exp_e.wr, exp_e.wd);
      else pass_cnt++;
      total_cnt++;
      if (wlog[n0+k].c != wlog[n0].c + k)
        $display("FAIL cont_no_bubble[%0d]: got cycle %0d want %0d", k, wlog[n0+k].c, wlog[n0].c + k);
      else pass_cnt++;
    end
    $display("test_contention done");
  endtask

  task automatic test_backpressure();
    int n0, na, nb;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_tab[i].wr = AW'(1 + i);  a_tab[i].wd = 32'h0A0A_0000 + i;
      b_tab[i].wr = AW'(16 + i); b_tab[i].wd = 32'h0B0B_0000 + i;
    end
    n0 = wlog.size();
    run_streams(4, 4);
    total_cnt++; if (b_stall == 0) $display("FAIL bp_b_ready_low: got %0d stalled cycles want >0", b_stall); else pass_cnt++;
    total_cnt++; if (wlog.size() - n0 != 8) $display("FAIL bp_count: got %0d writes want 8", wlog.size() - n0); else pass_cnt++;
    na = 0;
    nb = 0;
    for (int k = n0; k < wlog.size(); k++) begin
      if (wlog[k].wr < 5'd16) begin
        if (na < 4) begin
          total_cnt++;
          if (wlog[k].wr !== a_tab[na].wr || wlog[k].wd !== a_tab[na].wd)
            $display("FAIL bp_a_order[%0d]: got r%0d=%h want r%0d=%h", na, wlog[k].wr, wlog[k].wd, a_tab[na].wr, a_tab[na].wd);
          else pass_cnt++;
        end
        na++;
      end else begin
        if (nb < 4) begin
          total_cnt++;
          if (wlog[k].wr !== b_tab[nb].wr || wlog[k].wd !== b_tab[nb].wd)
            $display("FAIL bp_b_order[%0d]: got r%0d=%h want r%0d=%h", nb, wlog[k].wr, wlog[k].wd, b_tab[nb].wr, b_tab[nb].wd);
          else pass_cnt++;
        end
        nb++;
      end
    end
    total_cnt++; if (na != 4 || nb != 4) $display("FAIL bp_split: got a=%0d b=%0d want 4/4", na, nb); else pass_cnt++;
    $display("test_backpressure done");
  endtask

  task automatic test_same_reg();
    do_reset();
    A_VALID = 1'b1; A_WR = 5'd7; A_WD = 32'd1;
    B_VALID = 1'b1; B_WR = 5'd7; B_WD = 32'd2;
    RR1 = 5'd7; RR2 = 5'd8;
    tick();
    A_VALID = 1'b0; B_VALID = 1'b0;
    total_cnt++; if (HAZ1 !== 1'b1 || HAZ2 !== 1'b0) $display("FAIL race_haz_queued: got %b%b want 10", HAZ1, HAZ2); else pass_cnt++;
    tick();
    total_cnt++; if (WE !== 1'b1 || WR !== 5'd7 || WD !== 32'd1)
      $display("FAIL race_first: got we=%b wr=%0d wd=%0d want we=1 wr=7 wd=1", WE, WR, WD); else pass_cnt++;
    tick();
    total_cnt++; if (WE !== 1'b1 || WR !== 5'd7 || WD !== 32'd2)
      $display("FAIL race_second: got we=%b wr=%0d wd=%0d want we=1 wr=7 wd=2", WE, WR, WD); else pass_cnt++;
    total_cnt++; if (HAZ1 !== 1'b1 || rf[7] !== 32'd1) $display("FAIL race_mid: got haz1=%b rf7=%0d want 1/1", HAZ1, rf[7]); else pass_cnt++;
    tick();
    total_cnt++; if (HAZ1 !== 1'b0 || WE !== 1'b0) $display("FAIL race_done: got haz1=%b we=%b want 0/0", HAZ1, WE); else pass_cnt++;
    total_cnt++; if (rf[7] !== 32'd2) $display("FAIL race_rf: got %0d want 2", rf[7]); else pass_cnt++;
    $display("test_same_reg done");
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    n0 = wlog.size();
    A_VALID = 1'b1; A_WR = 5'd20; A_WD = 32'h2020;
    B_VALID = 1'b1; B_WR = 5'd21; B_WD = 32'h2121;
    RR1 = 5'd21; RR2 = 5'd23;
    tick();
    A_WR = 5'd22; A_WD = 32'h2222;
    B_WR = 5'd23; B_WD = 32'h2323;
    tick();
    A_VALID = 1'b0; B_VALID = 1'b0;
    total_cnt++; if (HAZ1 !== 1'b1 || HAZ2 !== 1'b1 || IDLE !== 1'b0)
      $display("FAIL mid_pre: got haz=%b%b idle=%b want 11/0", HAZ1, HAZ2, IDLE); else pass_cnt++;
    RST_N = 1'b0;
    tick();
    total_cnt++; if (WE !== 1'b0 || IDLE !== 1'b1) $display("FAIL mid_after_rst: got we=%b idle=%b want 0/1", WE, IDLE); else pass_cnt++;
    total_cnt++; if (HAZ1 !== 1'b0 || HAZ2 !== 1'b0) $display("FAIL mid_haz: got %b%b want 00", HAZ1, HAZ2); else pass_cnt++;
    RST_N = 1'b1;
    tick();
    total_cnt++; if (WE !== 1'b0) $display("FAIL mid_no_pulse: got %b want 0", WE); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (wlog.size() != n0 + 1) $display("FAIL mid_writes: got %0d writes want 1", wlog.size() - n0); else pass_cnt++;
    if (wlog.size() > n0) begin
      total_cnt++; if (wlog[wlog.size()-1].wr !== 5'd20) $display("FAIL mid_last_wr: got r%0d want r20", wlog[wlog.size()-1].wr); else pass_cnt++;
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_reg0();
    test_contention();
    test_backpressure();
    test_same_reg();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
